stochastic_sng: RTL and testbench

STOCHASTIC_SNG -- requirements
Module: stochastic_sng

---
 rtl/stochastic_pkg.sv | 32 +++
 rtl/sng_lfsr8.sv | 37 +++
 rtl/stochastic_sng.sv | 114 +++++++++++
 tb/tb_stochastic_sng.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/stochastic_pkg.sv
// Shared constants, state encoding and LFSR step for the stochastic number generator.
package stochastic_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  localparam int LFSR_W     = 8;
  localparam int STREAM_LEN = 255;
  localparam int NUM_PIX    = 8;

  // Taps for x^8+x^6+x^5+x^4+1 in a left-shifting Fibonacci register.
  localparam logic [LFSR_W-1:0] TAP_MASK = 8'hB8;
  localparam logic [LFSR_W-1:0] SEED_A   = 8'h01;
  localparam logic [LFSR_W-1:0] SEED_B   = 8'hA5;
  localparam logic [LFSR_W-1:0] SEED_C   = 8'h5C;

  localparam int PIX_Z1 = 0;
  localparam int PIX_Z2 = 1;
  localparam int PIX_Z3 = 2;
  localparam int PIX_Z4 = 3;
  localparam int PIX_Z6 = 4;
  localparam int PIX_Z7 = 5;
  localparam int PIX_Z8 = 6;
  localparam int PIX_Z9 = 7;

  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] q);
    return {q[LFSR_W-2:0], ^(q & TAP_MASK)};
  endfunction

endpackage

// File: rtl/sng_lfsr8.sv
// 8-bit maximal-length Fibonacci LFSR with synchronous seed load and advance.
module sng_lfsr8
  import stochastic_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = SEED_A
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              adv_i,
  output logic [LFSR_W-1:0] state_o
);

  logic [LFSR_W-1:0] lfsr_q, lfsr_d;

  // NOTE: default assignment first so every path drives lfsr_d -- no latch.
  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = SEED;
    end else if (adv_i) begin
      lfsr_d = lfsr_next(lfsr_q);
    end
  end

  // NOTE: non-blocking in clocked blocks so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/stochastic_sng.sv
// Converts an 8-pixel neighbourhood into two decorrelated 255-bit stochastic streams
// per pixel plus five ~0.5 select streams.
module stochastic_sng
  import stochastic_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [63:0] pix,
  output logic        z1_1, z2_1, z3_1, z4_1, z6_1, z7_1, z8_1, z9_1,
  output logic        z1_2, z2_2, z3_2, z4_2, z6_2, z7_2, z8_2, z9_2,
  output logic        r0, r1, r2, r3, r4,
  output logic        bs_valid,
  output logic        bs_last
);

  localparam logic [7:0] LAST_CNT = 8'(STREAM_LEN - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [63:0]       pix_q, pix_d;
  logic              alive_q;
  logic              lfsr_load, lfsr_adv;
  logic [LFSR_W-1:0] lfsr_a, lfsr_b, lfsr_c;
  logic [NUM_PIX-1:0] hit_a, hit_b;
  logic              unused_c;

  sng_lfsr8 #(.SEED(SEED_A)) u_lfsr_a (.clk(clk), .rst_n(rst), .load_i(lfsr_load), .adv_i(lfsr_adv), .state_o(lfsr_a));
  sng_lfsr8 #(.SEED(SEED_B)) u_lfsr_b (.clk(clk), .rst_n(rst), .load_i(lfsr_load), .adv_i(lfsr_adv), .state_o(lfsr_b));
  sng_lfsr8 #(.SEED(SEED_C)) u_lfsr_c (.clk(clk), .rst_n(rst), .load_i(lfsr_load), .adv_i(lfsr_adv), .state_o(lfsr_c));

  assign unused_c = ^lfsr_c[7:5];

  // alive_q keeps start_ready low until the first edge after reset release.
  assign start_ready = alive_q && (state_q == IDLE);
  assign bs_valid    = (state_q == STREAM);
  assign bs_last     = bs_valid && (cnt_q == LAST_CNT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pix_d     = pix_q;
    lfsr_load = 1'b0;
    lfsr_adv  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_valid && start_ready) begin
          state_d   = STREAM;
          pix_d     = pix;
          cnt_d     = 8'd0;
          lfsr_load = 1'b1;
        end
      end
      STREAM: begin
        lfsr_adv = 1'b1;
        cnt_d    = cnt_q + 8'd1;
        if (cnt_q == LAST_CNT) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      pix_q   <= 64'd0;
      alive_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pix_q   <= pix_d;
      alive_q <= 1'b1;
    end
  end

  // A pixel bit is 1 when the value is at least the LFSR sample; gated to 0 outside STREAM.
  always_comb begin
    hit_a = '0;
    hit_b = '0;
    for (int k = 0; k < NUM_PIX; k++) begin
      hit_a[k] = bs_valid && (pix_q[8*k +: 8] >= lfsr_a);
      hit_b[k] = bs_valid && (pix_q[8*k +: 8] >= lfsr_b);
    end
  end

  assign z1_1 = hit_a[PIX_Z1];
  assign z2_1 = hit_a[PIX_Z2];
  assign z3_1 = hit_a[PIX_Z3];
  assign z4_1 = hit_a[PIX_Z4];
  assign z6_1 = hit_a[PIX_Z6];
  assign z7_1 = hit_a[PIX_Z7];
  assign z8_1 = hit_a[PIX_Z8];
  assign z9_1 = hit_a[PIX_Z9];

  assign z1_2 = hit_b[PIX_Z1];
  assign z2_2 = hit_b[PIX_Z2];
  assign z3_2 = hit_b[PIX_Z3];
  assign z4_2 = hit_b[PIX_Z4];
  assign z6_2 = hit_b[PIX_Z6];
  assign z7_2 = hit_b[PIX_Z7];
  assign z8_2 = hit_b[PIX_Z8];
  assign z9_2 = hit_b[PIX_Z9];

  assign r0 = bs_valid && lfsr_c[0];
  assign r1 = bs_valid && lfsr_c[1];
  assign r2 = bs_valid && lfsr_c[2];
  assign r3 = bs_valid && lfsr_c[3];
  assign r4 = bs_valid && lfsr_c[4];

endmodule

// File: tb/tb_stochastic_sng.sv
// Scoreboard bench: stimulus pushes expected per-stream counts, a monitor tallies and compares.
module tb_stochastic_sng;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start_valid = 1'b0;
  logic        start_ready;
  logic [63:0] pix = 64'd0;
  logic        z1_1, z2_1, z3_1, z4_1, z6_1, z7_1, z8_1, z9_1;
  logic        z1_2, z2_2, z3_2, z4_2, z6_2, z7_2, z8_2, z9_2;
  logic        r0, r1, r2, r3, r4;
  logic        bs_valid, bs_last;

  stochastic_sng dut (
    .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready), .pix(pix),
    .z1_1(z1_1), .z2_1(z2_1), .z3_1(z3_1), .z4_1(z4_1), .z6_1(z6_1), .z7_1(z7_1), .z8_1(z8_1), .z9_1(z9_1),
    .z1_2(z1_2), .z2_2(z2_2), .z3_2(z3_2), .z4_2(z4_2), .z6_2(z6_2), .z7_2(z7_2), .z8_2(z8_2), .z9_2(z9_2),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4),
    .bs_valid(bs_valid), .bs_last(bs_last)
  );

  always #5 clk = ~clk;

  logic [7:0] za, zb;
  logic [4:0] rv;
  assign za = {z9_1, z8_1, z7_1, z6_1, z4_1, z3_1, z2_1, z1_1};
  assign zb = {z9_2, z8_2, z7_2, z6_2, z4_2, z3_2, z2_2, z1_2};
  assign rv = {r4, r3, r2, r1, r0};

  typedef struct {
    int c[8];
    bit decor;
    bit pos;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push_uniform(input int v, input bit decor);
    exp_t e;
    for (int k = 0; k < 8; k++) e.c[k] = v;
    e.decor = decor;
    e.pos   = 1'b0;
    exp_q.push_back(e);
  endtask

  // Monitor
  int vcnt, agree, first_z2, ready_viol, idle_viol;
  int c1[8], c2[8], rc[5];

  task automatic clear_acc();
    vcnt = 0; agree = 0; first_z2 = -1; ready_viol = 0;
    for (int k = 0; k < 8; k++) begin c1[k] = 0; c2[k] = 0; end
    for (int i = 0; i < 5; i++) rc[i] = 0;
  endtask

  initial begin
    idle_viol = 0;
    clear_acc();
    forever begin
      @(negedge clk);
      if (!rst) begin
        clear_acc();
      end else if (!bs_valid) begin
        if ({za, zb, rv, bs_last} != '0) idle_viol++;
      end else begin
        for (int k = 0; k < 8; k++) begin c1[k] += int'(za[k]); c2[k] += int'(zb[k]); end
        for (int i = 0; i < 5; i++) rc[i] += int'(rv[i]);
        if (za[0] == zb[0]) agree++;
        if (za[1] && first_z2 < 0) first_z2 = vcnt;
        if (start_ready) ready_viol++;
        if (bs_last) begin
          exp_t e;
          check("last_position", vcnt, 254);
          check("ready_low_in_stream", ready_viol, 0);
          check("stream_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            for (int k = 0; k < 8; k++) begin
              check($sformatf("count_a_z%0d", k), c1[k], e.c[k]);
              check($sformatf("count_b_z%0d", k), c2[k], e.c[k]);
            end
            for (int i = 0; i < 5; i++)
              check($sformatf("r%0d_ones_127_128 (ones=%0d)", i, rc[i]), int'(rc[i] >= 127 && rc[i] <= 128), 1);
            if (e.decor) check($sformatf("decor_agree_le_160 (agree=%0d)", agree), int'(agree <= 160), 1);
            if (e.pos) check("first_one_z2_1", first_z2, 0);
          end
          clear_acc();
        end else begin
          vcnt++;
        end
      end
    end
  end

  task automatic wait_ready(input string name);
    int n = 0;
    while (!start_ready && n < 400) begin @(negedge clk); n++; end
    check(name, int'(start_ready), 1);
  endtask

  task automatic wait_last(input string name);
    int n = 0;
    while (!bs_last && n < 300) begin @(negedge clk); n++; end
    check(name, int'(bs_last), 1);
  endtask

  // Stimulus
  initial begin
    int acc[$];
    logic [7:0] ma, mb, mc;
    int mism;
    exp_t e;

    #12;
    check("rst_start_ready", int'(start_ready), 0);
    check("rst_bs_valid", int'(bs_valid), 0);
    check("rst_bs_last", int'(bs_last), 0);
    check("rst_outputs_zero", int'({za, zb, rv}), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("ready_after_release", int'(start_ready), 1);

    // All pixels 0x80
    pix = {8{8'h80}};
    start_valid = 1'b1;
    push_uniform(128, 1'b1);
    @(negedge clk);
    start_valid = 1'b0;
    wait_last("t1_last_seen");
    @(negedge clk);
    wait_ready("t1_ready");

    // Boundary values: z1=0, z9=255, others 1
    pix = {8'hFF, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h00};
    e.c = '{0, 1, 1, 1, 1, 1, 1, 255};
    e.decor = 1'b0;
    e.pos = 1'b1;
    exp_q.push_back(e);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    wait_last("t2_last_seen");
    @(negedge clk);
    wait_ready("t2_ready");

    // start_valid held high; pix disturbed mid-stream
    pix = {8{8'h40}};
    push_uniform(64, 1'b0);
    push_uniform(32, 1'b0);
    push_uniform(16, 1'b0);
    start_valid = 1'b1;
    for (int cyc = 0; cyc < 780; cyc++) begin
      if (start_ready && start_valid) acc.push_back(cyc);
      if (acc.size() == 3 && cyc > acc[2]) start_valid = 1'b0;
      case (cyc)
        100: pix = {8{8'hFF}};
        200: pix = {8{8'h20}};
        356: pix = {8{8'hFF}};
        456: pix = {8{8'h10}};
        default: ;
      endcase
      @(negedge clk);
    end
    start_valid = 1'b0;
    check("accept_count", acc.size(), 3);
    if (acc.size() >= 3) begin
      check("accept0_cycle", acc[0], 0);
      check("accept1_cycle", acc[1], 256);
      check("accept2_cycle", acc[2], 512);
    end
    wait_ready("t3_ready");

    // Reset during stream at valid cycle 100
    pix = {8{8'h80}};
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("abort_bs_valid", int'(bs_valid), 0);
    check("abort_outputs_zero", int'({za, zb, rv}), 0);
    check("abort_bs_last", int'(bs_last), 0);
    check("abort_start_ready", int'(start_ready), 0);
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    check("ready_after_abort", int'(start_ready), 1);

    // Fresh stream must reproduce the seed sequence bit-exactly
    pix = {8{8'h80}};
    push_uniform(128, 1'b1);
    start_valid = 1'b1;
    @(negedge clk);
    start_valid = 1'b0;
    ma = 8'h01; mb = 8'hA5; mc = 8'h5C;
    mism = 0;
    for (int i = 0; i < 255; i++) begin
      if (!bs_valid || za != {8{ma <= 8'h80}} || zb != {8{mb <= 8'h80}} || rv != mc[4:0]) mism++;
      ma = {ma[6:0], ma[7] ^ ma[5] ^ ma[4] ^ ma[3]};
      mb = {mb[6:0], mb[7] ^ mb[5] ^ mb[4] ^ mb[3]};
      mc = {mc[6:0], mc[7] ^ mc[5] ^ mc[4] ^ mc[3]};
      if (i < 254) @(negedge clk);
    end
    check("seed_sequence_mismatches", mism, 0);
    @(negedge clk);
    wait_ready("t4_ready");

    repeat (4) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("idle_outputs_zero", idle_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
